fetch_controller: RTL

Sequencer for the synchronous instruction memory: owns the PC and issues one read address per cycle. It tracks the single in-flight read (1-cycle memory latency) and delivers instructions to decode with a valid/stall handshake. It handles branch redirects, HALT detection and out-of-range PCs, and sits between the instruction memory and the decode stage.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_skid_buffer.sv | 43 ++++
 rtl/fetch_controller.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// The opcode field position is fixed by the ISA, independent of INSTR_WIDTH.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    localparam logic [5:0] HALT_OPCODE = 6'b111111;
    localparam int         OPCODE_MSB  = 31;
    localparam int         OPCODE_LSB  = 26;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a returning instruction read while decode stalls.
// Flush wins over load, and load wins over drain, so drain+load replaces the entry.
module fetch_skid_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  drain_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [PC_WIDTH-1:0]   pc_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [PC_WIDTH-1:0]   pc_o,
    output logic                  valid_o
);

    logic [DATA_WIDTH-1:0] data_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic                  valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            pc_q    <= pc_i;
            valid_q <= 1'b1;
        end else if (drain_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_controller.sv
// PC sequencer for a synchronous instruction memory: issues one address per cycle,
// tracks the outstanding reads and delivers words to decode through a valid/stall handshake.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH    = 7,
    parameter int INSTR_WIDTH = 32,
    parameter int MEM_DEPTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [PC_WIDTH-1:0]    start_pc,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    instr_pc,
    output logic                   instr_valid,
    output logic                   halted,
    output logic                   addr_error
);

    localparam logic [31:0] DEPTH_U = 32'(MEM_DEPTH);
    localparam logic [31:0] LAST_U  = DEPTH_U - 32'd1;

    function automatic logic in_range(input logic [PC_WIDTH-1:0] p);
        return 32'(p) < DEPTH_U;
    endfunction

    function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] p);
        if (32'(p) == LAST_U) return '0;
        return p + PC_WIDTH'(1);
    endfunction

    fetch_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    addr_q, addr_d;
    // req: address on the bus this cycle; dat: its word is on imem_rdata this cycle
    logic                   req_q, req_d;
    logic [PC_WIDTH-1:0]    req_pc_q, req_pc_d;
    logic                   dat_q, dat_d;
    logic [PC_WIDTH-1:0]    dat_pc_q, dat_pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]    instr_pc_q, instr_pc_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;

    logic                   skid_load, skid_drain, skid_flush, skid_valid;
    logic [INSTR_WIDTH-1:0] skid_data;
    logic [PC_WIDTH-1:0]    skid_pc;

    logic                   out_free, load_en, halting, issue;
    logic [INSTR_WIDTH-1:0] load_word;
    logic [PC_WIDTH-1:0]    load_pc;

    fetch_skid_buffer #(
        .DATA_WIDTH(INSTR_WIDTH),
        .PC_WIDTH  (PC_WIDTH)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load_i (skid_load),
        .drain_i(skid_drain),
        .flush_i(skid_flush),
        .data_i (imem_rdata),
        .pc_i   (dat_pc_q),
        .data_o (skid_data),
        .pc_o   (skid_pc),
        .valid_o(skid_valid)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        req_d      = 1'b0;
        req_pc_d   = req_pc_q;
        dat_d      = dat_q;
        dat_pc_d   = dat_pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        err_d      = err_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_flush = 1'b0;
        out_free   = !valid_q || !stall;
        load_en    = 1'b0;
        load_word  = imem_rdata;
        load_pc    = dat_pc_q;
        halting    = 1'b0;
        issue      = 1'b0;

        case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    valid_d    = 1'b0;
                    dat_d      = 1'b0;
                    skid_flush = 1'b1;
                    if (in_range(redirect_pc)) begin
                        pc_d = redirect_pc;
                    end else begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end
                end else begin
                    if (out_free) begin
                        if (skid_valid) begin
                            load_en    = 1'b1;
                            load_word  = skid_data;
                            load_pc    = skid_pc;
                            skid_drain = 1'b1;
                            skid_load  = dat_q;
                        end else if (dat_q) begin
                            load_en = 1'b1;
                        end else begin
                            valid_d = 1'b0;
                        end
                    end else if (dat_q && !skid_valid) begin
                        skid_load = 1'b1;
                    end
                    // With output and skid both full the word stays parked on the
                    // memory bus: no issue can happen, so imem_addr is unchanged.
                    if (out_free || !skid_valid) begin
                        dat_d    = req_q;
                        dat_pc_d = req_pc_q;
                    end
                    if (load_en) begin
                        instr_d    = load_word;
                        instr_pc_d = load_pc;
                        valid_d    = 1'b1;
                    end
                    halting = load_en && (load_word[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);
                    if (halting) begin
                        state_d    = HALT;
                        dat_d      = 1'b0;
                        skid_flush = 1'b1;
                    end
                    issue = !stall && !skid_valid && !halting;
                    if (issue) begin
                        addr_d   = pc_q;
                        req_d    = 1'b1;
                        req_pc_d = pc_q;
                        pc_d     = pc_inc(pc_q);
                    end
                end
            end
            default: begin
                if (valid_q && !stall) valid_d = 1'b0;
                if (start) begin
                    if (in_range(start_pc)) begin
                        state_d  = FETCH;
                        addr_d   = start_pc;
                        req_d    = 1'b1;
                        req_pc_d = start_pc;
                        pc_d     = pc_inc(start_pc);
                    end else begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            addr_q     <= '0;
            req_q      <= 1'b0;
            req_pc_q   <= '0;
            dat_q      <= 1'b0;
            dat_pc_q   <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            req_pc_q   <= req_pc_d;
            dat_q      <= dat_d;
            dat_pc_q   <= dat_pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign halted      = (state_q == HALT);
    assign addr_error  = err_q;

endmodule
